// File: rtl/prime_factor.sv
// Trial-division prime factoriser: accepts one number on go and streams its
// prime factors smallest first (with repeats) over a valid/ack interface.
module prime_factor #(
  parameter int WIDTH_LOG = 4,
  localparam int WIDTH = 1 << WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             error,
  output logic             fac_valid,
  output logic [WIDTH-1:0] fac,
  output logic             fac_last,
  input  logic             fac_ack,
  output logic [2:0]       state
);

  // Handshakes: a command is taken on a clock edge where go=1 and ready=1;
  // a factor is taken on a clock edge where fac_valid=1 and fac_ack=1.
  // fac/fac_last are stable while fac_valid=1 and not yet taken.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERR   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

  localparam logic [WIDTH_LOG-1:0] CNT_LAST = WIDTH_LOG'(WIDTH - 1);
  localparam logic [WIDTH+1:0]     DSQ_FOUR = (WIDTH+2)'(4);
  localparam logic [WIDTH+1:0]     DSQ_NINE = (WIDTH+2)'(9);

  logic [2:0]           state_nx;
  logic [WIDTH-1:0]     m, m_nx;
  logic [WIDTH-1:0]     d, d_nx;
  logic [WIDTH+1:0]     dsq, dsq_nx;
  logic [WIDTH-1:0]     q, q_nx;
  logic [WIDTH-1:0]     r, r_nx;
  logic [WIDTH_LOG-1:0] cnt, cnt_nx;

  logic [WIDTH:0]       r_sh;
  logic [WIDTH:0]       r_sub;
  logic                 take;

  logic                 ready_nx;
  logic                 error_nx;
  logic                 fac_valid_nx;
  logic [WIDTH-1:0]     fac_nx;
  logic                 fac_last_nx;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      m         <= '0;
      d         <= '0;
      dsq       <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      ready     <= 1'b1;
      error     <= 1'b0;
      fac_valid <= 1'b0;
      fac       <= '0;
      fac_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      m         <= m_nx;
      d         <= d_nx;
      dsq       <= dsq_nx;
      q         <= q_nx;
      r         <= r_nx;
      cnt       <= cnt_nx;
      ready     <= ready_nx;
      error     <= error_nx;
      fac_valid <= fac_valid_nx;
      fac       <= fac_nx;
      fac_last  <= fac_last_nx;
    end
  end

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    r_sub = r_sh - {1'b0, d};
    take  = (r_sh >= {1'b0, d});
  end

  // Next state and datapath.
  always_comb begin
    state_nx = state;
    m_nx     = m;
    d_nx     = d;
    dsq_nx   = dsq;
    q_nx     = q;
    r_nx     = r;
    cnt_nx   = cnt;
    case (state)
      S_IDLE, S_ERR: begin
        if (go) begin
          if (n == '0) begin
            state_nx = S_ERR;
          end else begin
            m_nx     = n;
            d_nx     = WIDTH'(2);
            dsq_nx   = DSQ_FOUR;
            state_nx = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (dsq > {2'b00, m}) begin
          state_nx = (m > WIDTH'(1)) ? S_EMIT : S_IDLE;
        end else begin
          q_nx     = m;
          r_nx     = '0;
          cnt_nx   = '0;
          state_nx = S_DIV;
        end
      end
      S_DIV: begin
        q_nx   = {q[WIDTH-2:0], take};
        r_nx   = take ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          if (r_nx == '0) begin
            // Keep d so a repeated factor is found again on the next pass.
            m_nx     = q_nx;
            state_nx = S_EMIT;
          end else begin
            if (d == WIDTH'(2)) begin
              d_nx   = WIDTH'(3);
              dsq_nx = DSQ_NINE;
            end else begin
              // (d+2)^2 = d^2 + 4d + 4
              d_nx   = d + WIDTH'(2);
              dsq_nx = dsq + {d, 2'b00} + DSQ_FOUR;
            end
            state_nx = S_CHECK;
          end
        end
      end
      S_EMIT: begin
        if (fac_ack) begin
          state_nx = fac_last ? S_IDLE : S_CHECK;
        end
      end
      default: begin
        state_nx = 'x;
        m_nx     = 'x;
        d_nx     = 'x;
        dsq_nx   = 'x;
        q_nx     = 'x;
        r_nx     = 'x;
        cnt_nx   = 'x;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ready_nx     = (state_nx == S_IDLE) || (state_nx == S_ERR);
    error_nx     = (state_nx == S_ERR);
    fac_valid_nx = (state_nx == S_EMIT);
    fac_nx       = fac;
    fac_last_nx  = fac_last;
    if (state == S_CHECK && state_nx == S_EMIT) begin
      fac_nx      = m;
      fac_last_nx = 1'b1;
    end else if (state == S_DIV && state_nx == S_EMIT) begin
      fac_nx      = d;
      fac_last_nx = 1'b0;
    end
  end

endmodule
